io_bus_bridge: RTL and testbench
================================

Name: io_bus_bridge

Overview:
- Parametrised successor to the fixed gate-array I/O strobe logic.
- Converts one CPU I/O bus cycle into a timed peripheral access on one of NCH channels: per-channel CSn, shared RDn/WRn, setup/strobe/hold phases, BUSYn wait-stretching and registered read data.
- Returns READYn to the CPU.
- Sits between the address decoder (which supplies IO_CEn) and the peripherals (video controllers, palette chip, future I/O).

Parameters:
NCH, 4, number of peripheral channels (1..16)
AW, 32, CPU address width
DW, 16, data width per channel
SEL_LSB, 8, lowest address bit of the channel-index field; index = A[SEL_LSB +: CW], CW = max(1, clog2(NCH))
SETUP_CYC, 1, CE cycles CSn is active before the strobe (0 allowed)
STROBE_CYC, 2, minimum CE cycles the strobe is active (>=1)
HOLD_CYC, 1, CE cycles CSn stays active after the strobe (0 allowed)
TIMEOUT_CYC, 1023, maximum CE cycles spent in WAIT (requires IO_BRIDGE_TIMEOUT_EN)

Ports:
CLK  in  1  system clock
RESn  in  1  asynchronous active-low reset
CE  in  1  clock enable; all state advances only when CE=1
A  in  AW  CPU address
DI  in  DW  CPU write data
DO  out  DW  read data to CPU; registered
MRQn  in  1  memory request, active low
RW  in  1  1=read, 0=write
BCYSTn  in  1  bus cycle start, active low
IO_CEn  in  1  I/O window select from the upstream decoder, active low
READYn  out  1  cycle complete, active low
CSn  out  NCH  per-channel chip select, active low
RDn  out  1  read strobe, active low
WRn  out  1  write strobe, active low
PDO  out  DW  write data to peripherals; latched at cycle start
PDI  in  NCH*DW  peripheral read data; channel i on bits [i*DW +: DW]
BUSYn  in  NCH  per-channel wait request, active low
TOUT  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset values: CSn all 1, RDn=1, WRn=1, READYn=1, DO=0, PDO=0, TOUT=0, state IDLE. Reset mid-cycle aborts immediately with no READYn pulse.
- States: IDLE, SETUP, STROBE, WAIT, HOLD, DONE. Counter width is clog2 of the largest of SETUP_CYC, STROBE_CYC, HOLD_CYC, TIMEOUT_CYC, plus 1.
- IDLE:
  - Start condition: CE & ~BCYSTn & ~MRQn & ~IO_CEn.
  - On start, latch channel index, RW and DI (DI goes to PDO).
  - If index >= NCH (unmapped): go to DONE, assert no CSn, DO = all ones.
  - Else if SETUP_CYC>0: go to SETUP.
  - Else: go to STROBE.
- SETUP: CSn[ch]=0 and strobes inactive for exactly SETUP_CYC CE cycles, then STROBE.
- STROBE: CSn[ch]=0; RDn=0 if read, WRn=0 if write; held STROBE_CYC CE cycles. On the last cycle:
  - If BUSYn[ch]=0: go to WAIT.
  - Else: capture PDI[ch] into DO (reads only) and go to HOLD.
- WAIT:
  - Strobe and CSn stay asserted.
  - On the first CE cycle with BUSYn[ch]=1: capture DO (reads) and go to HOLD.
- HOLD: strobes deasserted, CSn[ch]=0 for HOLD_CYC CE cycles (0 means skip), then DONE.
- DONE:
  - READYn=0 for exactly one CE cycle. CSn all 1. Return to IDLE.
  - DO holds its value until the next captured read.
  - Write cycles leave DO unchanged.
- Bus rules:
  - BCYSTn seen outside IDLE is ignored; the CPU holds the cycle until READYn.
  - A start in the same CE cycle as DONE is not accepted; the earliest next start is the following CE cycle in IDLE.
- One-hot invariant: at most one CSn bit low at any time; RDn and WRn never low together; a strobe is never active without its CSn.
- CE=0: all outputs hold; counters frozen.
- Minimum read latency with defaults and no busy, start edge to READYn low: SETUP 1 + STROBE 2 + HOLD 1 + DONE = READYn low in the 5th CE cycle after the start cycle.

Optional Feature:
IO_BRIDGE_TIMEOUT_EN
- Defined:
  - WAIT counts CE cycles.
  - After TIMEOUT_CYC cycles with BUSYn[ch] still 0: go to HOLD, set DO = all ones (reads), set TOUT=1 (sticky).
- Undefined:
  - WAIT lasts indefinitely; TOUT tied to 0; TIMEOUT_CYC ignored; no timeout counter logic synthesised.

Test Plan:
- Default params; read ch2 (A=0x200), PDI ch2=0xBEEF, BUSYn all 1 -> CSn=4'b1011 for 4 CE cycles; RDn low exactly 2 cycles; READYn low 1 cycle in the 5th cycle; DO=0xBEEF.
- Write ch1 (A=0x100, DI=0x1234) -> PDO=0x1234 before WRn falls; WRn low 2 cycles; CSn=4'b1101; DO unchanged; READYn pulse.
- Read ch0, BUSYn[0] held low 7 extra CE cycles -> RDn low 2+7 cycles; data captured on the cycle BUSYn rises; READYn follows after HOLD.
- IO_BRIDGE_TIMEOUT_EN with TIMEOUT_CYC=8; BUSYn[3] stuck low -> exit WAIT after 8 cycles; DO=0xFFFF; TOUT=1 and stays 1 across the next normal cycle.
- NCH=3, access A=0x300 (index 3) -> no CSn or strobe; READYn low on the next CE cycle; DO=0xFFFF.
- Assert RESn low during STROBE -> all outputs return to reset values asynchronously; no READYn pulse; a new cycle after reset completes normally. CE toggling 1-of-3 stretches all phases by 3x with identical cycle counts in CE units.

Source files
------------

// File: rtl/io_bus_bridge_if.sv
// ============================================================================
// io_bus_bridge_if
// CPU-side and peripheral-side signal bundle for io_bus_bridge.
// The "slave" modport is the bridge; "master" is whoever plays CPU and
// peripherals around it.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_bus_bridge_if #(
  parameter int NCH = 4,
  parameter int AW  = 32,
  parameter int DW  = 16
);
  // CPU side
  logic [AW-1:0]     A;
  logic [DW-1:0]     DI;
  logic [DW-1:0]     DO;
  logic              MRQn;
  logic              RW;
  logic              BCYSTn;
  logic              IO_CEn;
  logic              READYn;
  // Peripheral side
  logic [NCH-1:0]    CSn;
  logic              RDn;
  logic              WRn;
  logic [DW-1:0]     PDO;
  logic [NCH*DW-1:0] PDI;
  logic [NCH-1:0]    BUSYn;
  logic              TOUT;

  modport slave (
    input  A, DI, MRQn, RW, BCYSTn, IO_CEn, PDI, BUSYn,
    output DO, READYn, CSn, RDn, WRn, PDO, TOUT
  );

  modport master (
    output A, DI, MRQn, RW, BCYSTn, IO_CEn, PDI, BUSYn,
    input  DO, READYn, CSn, RDn, WRn, PDO, TOUT
  );
endinterface

`default_nettype wire

// File: rtl/io_bus_bridge.sv
// ============================================================================
// io_bus_bridge
// Turns one CPU I/O bus cycle into a timed SETUP/STROBE/WAIT/HOLD access on
// one of NCH peripheral channels and answers the CPU with a READYn pulse.
// Optional build macro: IO_BRIDGE_TIMEOUT_EN (bounded WAIT + sticky TOUT).
// The interface instance must be built with the same NCH/AW/DW values.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bus_bridge #(
  parameter int NCH         = 4,
  parameter int AW          = 32,
  parameter int DW          = 16,
  parameter int SEL_LSB     = 8,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 2,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  wire logic      CLK,
  input  wire logic      RESn,
  input  wire logic      CE,
  io_bus_bridge_if.slave bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam int MAXC = imax(imax(SETUP_CYC, STROBE_CYC), imax(HOLD_CYC, TIMEOUT_CYC));
`else
  localparam int MAXC = imax(imax(SETUP_CYC, STROBE_CYC), HOLD_CYC);
`endif
  localparam int CNTW = $clog2(MAXC) + 1;
  localparam logic [CW:0] NCH_W = (CW+1)'(NCH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT, ST_HOLD, ST_DONE
  } state_t;

  state_t            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [CW-1:0]     ch_q;
  logic              rd_q;
  logic [NCH-1:0]    csn_q;
  logic              rdn_q;
  logic              wrn_q;
  logic              readyn_q;
  logic [DW-1:0]     do_q;
  logic [DW-1:0]     pdo_q;

  logic [CW-1:0]     sel_idx;
  logic              sel_unmapped;
  logic              start;
  logic              busy_sel;
  logic [DW-1:0]     pdi_sel;
  logic              leave;
  logic [DW-1:0]     leave_val;
`ifdef IO_BRIDGE_TIMEOUT_EN
  logic              tout_q;
  logic              timed_out;
`endif

  // Active-low one-hot chip select for a channel index
  function automatic logic [NCH-1:0] cs_dec(input logic [CW-1:0] ch);
    cs_dec = '1;
    for (int i = 0; i < NCH; i++) cs_dec[i] = (ch != CW'(i));
  endfunction

  assign sel_idx      = bus.A[SEL_LSB +: CW];
  assign sel_unmapped = ({1'b0, sel_idx} >= NCH_W);
  assign start        = ~bus.BCYSTn & ~bus.MRQn & ~bus.IO_CEn;

  // Pick the latched channel's BUSYn and read data
  always_comb begin
    busy_sel = 1'b1;
    pdi_sel  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CW'(i)) begin
        busy_sel = bus.BUSYn[i];
        pdi_sel  = bus.PDI[i*DW +: DW];
      end
    end
  end

  // Decide when the strobe ends and which value a read returns
  always_comb begin
    leave     = 1'b0;
    leave_val = pdi_sel;
`ifdef IO_BRIDGE_TIMEOUT_EN
    timed_out = 1'b0;
`endif
    case (state_q)
      ST_STROBE: leave = (cnt_q == '0) && busy_sel;
      ST_WAIT: begin
        if (busy_sel) begin
          leave = 1'b1;
        end
`ifdef IO_BRIDGE_TIMEOUT_EN
        else if (cnt_q == '0) begin
          leave     = 1'b1;
          leave_val = '1;
          timed_out = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Access sequencer with registered bus outputs; everything advances on CE only
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      rd_q     <= 1'b0;
      csn_q    <= '1;
      rdn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      readyn_q <= 1'b1;
      do_q     <= '0;
      pdo_q    <= '0;
`ifdef IO_BRIDGE_TIMEOUT_EN
      tout_q   <= 1'b0;
`endif
    end else if (CE) begin
      if (leave) begin
        rdn_q <= 1'b1;
        wrn_q <= 1'b1;
        if (rd_q) do_q <= leave_val;
`ifdef IO_BRIDGE_TIMEOUT_EN
        if (timed_out) tout_q <= 1'b1;
`endif
        if (HOLD_CYC > 0) begin
          state_q <= ST_HOLD;
          cnt_q   <= CNTW'(HOLD_CYC - 1);
        end else begin
          state_q  <= ST_DONE;
          csn_q    <= '1;
          readyn_q <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              ch_q  <= sel_idx;
              rd_q  <= bus.RW;
              pdo_q <= bus.DI;
              if (sel_unmapped) begin
                // Nothing answers here: finish at once with floating-bus data
                state_q  <= ST_DONE;
                readyn_q <= 1'b0;
                do_q     <= '1;
              end else if (SETUP_CYC > 0) begin
                state_q <= ST_SETUP;
                cnt_q   <= CNTW'(SETUP_CYC - 1);
                csn_q   <= cs_dec(sel_idx);
              end else begin
                state_q <= ST_STROBE;
                cnt_q   <= CNTW'(STROBE_CYC - 1);
                csn_q   <= cs_dec(sel_idx);
                rdn_q   <= ~bus.RW;
                wrn_q   <= bus.RW;
              end
            end
          end
          ST_SETUP: begin
            if (cnt_q == '0) begin
              state_q <= ST_STROBE;
              cnt_q   <= CNTW'(STROBE_CYC - 1);
              rdn_q   <= ~rd_q;
              wrn_q   <= rd_q;
            end else begin
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          ST_STROBE: begin
            // Reaching the last cycle here means the peripheral asked to wait
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNTW'(1);
            end else begin
              state_q <= ST_WAIT;
`ifdef IO_BRIDGE_TIMEOUT_EN
              cnt_q   <= CNTW'(TIMEOUT_CYC - 1);
`endif
            end
          end
          ST_WAIT: begin
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_q <= cnt_q - CNTW'(1);
`endif
          end
          ST_HOLD: begin
            if (cnt_q == '0) begin
              state_q  <= ST_DONE;
              csn_q    <= '1;
              readyn_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          ST_DONE: begin
            readyn_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.DO     = do_q;
  assign bus.READYn = readyn_q;
  assign bus.CSn    = csn_q;
  assign bus.RDn    = rdn_q;
  assign bus.WRn    = wrn_q;
  assign bus.PDO    = pdo_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
  assign bus.TOUT   = tout_q;
`else
  assign bus.TOUT   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_bus_bridge.sv
// ============================================================================
// tb_io_bus_bridge
// Scoreboard bench for io_bus_bridge: each bus cycle pushes its expected
// timing/data record, a negedge monitor measures the cycle in CE units and
// pops/compares when READYn falls. A second NCH=3 instance covers the
// unmapped-channel path.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_io_bus_bridge;
  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 16;
`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1023;
`endif

  logic CLK  = 1'b0;
  logic RESn = 1'b0;
  logic CE   = 1'b1;
  int   ce_div = 1;
  int   ce_ph  = 0;

  io_bus_bridge_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();
  io_bus_bridge_if #(.NCH(3),   .AW(AW), .DW(DW)) bus3 ();

  io_bus_bridge #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO_CYC)) u_dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .bus(bus)
  );

  io_bus_bridge #(.NCH(3), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO_CYC)) u_dut3 (
    .CLK(CLK), .RESn(RESn), .CE(CE), .bus(bus3)
  );

  always #5 CLK = ~CLK;

  // Clock enable: one CE cycle every ce_div clocks
  always @(posedge CLK) begin
    #1;
    ce_ph = (ce_ph + 1 >= ce_div) ? 0 : ce_ph + 1;
    CE    = (ce_ph == 0);
  end

  typedef struct {
    int          lat;
    int          cs;
    int          rd;
    int          wr;
    logic [3:0]  pat;
    logic [15:0] dov;
    logic [15:0] pdo;
    logic        tout;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int lat, input int cs, input int rd, input int wr,
                              input logic [3:0] pat, input logic [15:0] dov,
                              input logic [15:0] pdo, input logic tout);
    exp_t e;
    e.lat = lat; e.cs = cs; e.rd = rd; e.wr = wr;
    e.pat = pat; e.dov = dov; e.pdo = pdo; e.tout = tout;
    return e;
  endfunction

  function automatic int zeros(input logic [3:0] v);
    int z = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) z++;
    return z;
  endfunction

  // Monitor state
  bit          in_txn   = 0;
  int          cyc      = 0;
  int          cs_cnt   = 0;
  int          cs_bad   = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  int          viol     = 0;
  int          spur     = 0;
  logic [3:0]  pat      = 4'hF;
  logic [15:0] pdo_obs  = '0;

  // Measure each cycle in CE units and score it when READYn falls
  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RESn) begin
      in_txn = 0;
    end else if (CE) begin
      if (zeros(bus.CSn) > 1 || (!bus.RDn && !bus.WRn) ||
          ((!bus.RDn || !bus.WRn) && bus.CSn == 4'hF)) viol++;
      if (!in_txn) begin
        if (!bus.READYn) spur++;
        if (!bus.BCYSTn && !bus.MRQn && !bus.IO_CEn) begin
          in_txn = 1; cyc = 0; cs_cnt = 0; cs_bad = 0; rd_cnt = 0; wr_cnt = 0;
          pat = (exp_q.size() > 0) ? exp_q[0].pat : 4'hF;
        end
      end else begin
        cyc++;
        if (bus.CSn != 4'hF) begin
          cs_cnt++;
          if (bus.CSn != pat) cs_bad++;
        end
        if (!bus.RDn) rd_cnt++;
        if (!bus.WRn) begin
          if (wr_cnt == 0) pdo_obs = bus.PDO;
          wr_cnt++;
        end
        if (!bus.READYn) begin
          in_txn = 0;
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("latency",   cyc,    e.lat);
            chk("cs_cycles", cs_cnt, e.cs);
            chk("cs_wrong_channel", cs_bad, 0);
            chk("rd_cycles", rd_cnt, e.rd);
            chk("wr_cycles", wr_cnt, e.wr);
            chk("do",        bus.DO, e.dov);
            chk("tout",      bus.TOUT, e.tout);
            if (e.wr > 0) chk("pdo_at_wr", pdo_obs, e.pdo);
          end
        end
      end
    end
  end

  // One complete CPU bus cycle: start in a CE cycle, hold until READYn
  task automatic bus_cycle(input logic [31:0] addr, input logic rw,
                           input logic [15:0] di, input exp_t e);
    int d0;
    int n;
    exp_q.push_back(e);
    @(posedge CLK); #2;
    while (!CE) begin @(posedge CLK); #2; end
    bus.A = addr; bus.RW = rw; bus.DI = di;
    bus.MRQn = 1'b0; bus.IO_CEn = 1'b0; bus.BCYSTn = 1'b0;
    d0 = done_cnt;
    @(posedge CLK); #2;
    bus.BCYSTn = 1'b1;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin @(posedge CLK); n++; end
    if (done_cnt == d0) chk("ready_wait_expired", 0, 1);
    #2;
    bus.MRQn = 1'b1; bus.IO_CEn = 1'b1;
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    bus.A = '0; bus.DI = '0; bus.RW = 1'b1;
    bus.MRQn = 1'b1; bus.BCYSTn = 1'b1; bus.IO_CEn = 1'b1;
    bus.PDI = {16'h3333, 16'hBEEF, 16'h2222, 16'h1111};
    bus.BUSYn = '1;
    bus3.A = '0; bus3.DI = '0; bus3.RW = 1'b1;
    bus3.MRQn = 1'b1; bus3.BCYSTn = 1'b1; bus3.IO_CEn = 1'b1;
    bus3.PDI = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    bus3.BUSYn = '1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_csn",    bus.CSn, 4'hF);
    chk("rst_rdn",    bus.RDn, 1);
    chk("rst_wrn",    bus.WRn, 1);
    chk("rst_readyn", bus.READYn, 1);
    chk("rst_do",     bus.DO, 0);
    chk("rst_pdo",    bus.PDO, 0);
    chk("rst_tout",   bus.TOUT, 0);
    @(posedge CLK); #2;
    RESn = 1'b1;

    // Plain read of channel 2
    bus_cycle(32'h0000_0200, 1'b1, 16'h0000, mk(5, 4, 2, 0, 4'b1011, 16'hBEEF, 16'h0, 1'b0));
    // Write to channel 1; DO keeps the last read value
    bus_cycle(32'h0000_0100, 1'b0, 16'h1234, mk(5, 4, 0, 2, 4'b1101, 16'hBEEF, 16'h1234, 1'b0));

    // Read channel 0 with BUSYn low 7 extra cycles; data changes as BUSYn rises
    bus.BUSYn[0] = 1'b0;
    bus.PDI[15:0] = 16'h1111;
    fork
      bus_cycle(32'h0000_0000, 1'b1, 16'h0000, mk(12, 11, 9, 0, 4'b1110, 16'hCAFE, 16'h0, 1'b0));
      begin : rel
        int k;
        k = 0;
        while (!(in_txn && cyc == 9) && k < 200) begin @(negedge CLK); #1; k++; end
        @(posedge CLK); #2;
        bus.BUSYn[0] = 1'b1;
        bus.PDI[15:0] = 16'hCAFE;
      end
    join

    // CE at one-in-three: same counts in CE units
    ce_div = 3;
    bus_cycle(32'h0000_0300, 1'b1, 16'h0000, mk(5, 4, 2, 0, 4'b0111, 16'h3333, 16'h0, 1'b0));
    ce_div = 1;

    // Asynchronous reset in the middle of a strobe
    @(posedge CLK); #2;
    bus.A = 32'h0000_0200; bus.RW = 1'b1; bus.DI = 16'h5A5A;
    bus.MRQn = 1'b0; bus.IO_CEn = 1'b0; bus.BCYSTn = 1'b0;
    @(posedge CLK); #2;
    bus.BCYSTn = 1'b1;
    n = 0;
    while (!(in_txn && cyc == 2) && n < 100) begin @(negedge CLK); #1; n++; end
    chk("abort_rdn_before_reset", bus.RDn, 0);
    #3;
    RESn = 1'b0;
    #1;
    chk("abort_csn",    bus.CSn, 4'hF);
    chk("abort_rdn",    bus.RDn, 1);
    chk("abort_wrn",    bus.WRn, 1);
    chk("abort_readyn", bus.READYn, 1);
    chk("abort_do",     bus.DO, 0);
    chk("abort_pdo",    bus.PDO, 0);
    chk("abort_tout",   bus.TOUT, 0);
    bus.MRQn = 1'b1; bus.IO_CEn = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    RESn = 1'b1;
    repeat (8) @(negedge CLK);
    bus_cycle(32'h0000_0200, 1'b1, 16'h0000, mk(5, 4, 2, 0, 4'b1011, 16'hBEEF, 16'h0, 1'b0));

    // NCH=3 instance: index 3 is unmapped
    @(posedge CLK); #2;
    bus3.A = 32'h0000_0300; bus3.RW = 1'b1;
    bus3.MRQn = 1'b0; bus3.IO_CEn = 1'b0; bus3.BCYSTn = 1'b0;
    @(negedge CLK);
    chk("u3_readyn_start_cycle", bus3.READYn, 1);
    @(posedge CLK); #2;
    bus3.BCYSTn = 1'b1;
    @(negedge CLK);
    chk("u3_readyn", bus3.READYn, 0);
    chk("u3_csn",    bus3.CSn, 3'b111);
    chk("u3_rdn",    bus3.RDn, 1);
    chk("u3_do",     bus3.DO, 16'hFFFF);
    @(posedge CLK); #2;
    bus3.MRQn = 1'b1; bus3.IO_CEn = 1'b1;
    @(negedge CLK);
    chk("u3_readyn_after", bus3.READYn, 1);

`ifdef IO_BRIDGE_TIMEOUT_EN
    // Stuck BUSYn: WAIT gives up after TO_CYC cycles, TOUT sticks
    bus.BUSYn[3] = 1'b0;
    bus_cycle(32'h0000_0300, 1'b1, 16'h0000,
              mk(5 + TO_CYC, 4 + TO_CYC, 2 + TO_CYC, 0, 4'b0111, 16'hFFFF, 16'h0, 1'b1));
    bus.BUSYn[3] = 1'b1;
    bus_cycle(32'h0000_0100, 1'b0, 16'h0077, mk(5, 4, 0, 2, 4'b1101, 16'hFFFF, 16'h0077, 1'b1));
`endif

    repeat (4) @(negedge CLK);
    chk("invariant_violations", viol, 0);
    chk("spurious_ready",       spur, 0);
    chk("scoreboard_left",      exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
